// File: rtl/riscv_defs.sv
// Shared definitions for the execute stage: ALU op codes, forward selects, branch codes, M-unit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defs;

  // Bit 4 set marks the iterative M-extension ops; bit 2 within them separates divide from multiply.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_AND    = 5'h02,
    ALU_OR     = 5'h03,
    ALU_XOR    = 5'h04,
    ALU_SLL    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_SLT    = 5'h08,
    ALU_SLTU   = 5'h09,
    ALU_MUL    = 5'h10,
    ALU_MULH   = 5'h11,
    ALU_MULHSU = 5'h12,
    ALU_MULHU  = 5'h13,
    ALU_DIV    = 5'h14,
    ALU_DIVU   = 5'h15,
    ALU_REM    = 5'h16,
    ALU_REMU   = 5'h17
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        jal;
    logic        jalr;
    logic        zero;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_imm;
    logic [31:0] pc;
  } exmem_t;

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M unit: shift-add multiply / restoring divide, one bit per cycle.
// Latency: start in IDLE, 32 BUSY cycles, result valid for the single DONE cycle.
// Backpressure: none; abort_i in BUSY/DONE drops the operation and returns to IDLE.
// Ports: clk, rst_n (async active-low); start_i/abort_i; op_i, a_i, b_i; busy_o, done_o, result_o.
module muldiv_iter
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, op_q, op_d;
  logic [31:0] b_q, b_d;            // |multiplicand| or |divisor|
  logic [63:0] acc_q, acc_d;        // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic        negq_q, negq_d;      // negate product / quotient
  logic        negr_q, negr_d;      // negate remainder (follows dividend sign)
  logic        bzero_q, bzero_d;

  logic        a_sgn, b_sgn;
  logic [32:0] mul_sum, div_sh;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  // Operand signedness is decided from the incoming op so abs values can be latched at start.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      ALU_MULH, ALU_DIV, ALU_REM: begin a_sgn = a_i[31]; b_sgn = b_i[31]; end
      ALU_MULHSU:                 a_sgn = a_i[31];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bzero_d = bzero_q;
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh  = {acc_q[63:32], acc_q[31]};
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = 5'd0;
          op_d    = op_i;
          b_d     = b_sgn ? -b_i : b_i;
          acc_d   = {32'd0, (a_sgn ? -a_i : a_i)};
          negq_d  = a_sgn ^ b_sgn;
          negr_d  = a_sgn;
          bzero_d = (b_i == 32'd0);
        end
      end
      MD_BUSY: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (op_q[2]) begin
            if (div_sh >= {1'b0, b_q}) acc_d = {32'(div_sh - {1'b0, b_q}), acc_q[30:0], 1'b1};
            else                       acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          if (cnt_q == 5'd31) state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bzero_q <= bzero_d;
    end
  end

  // Divide-by-zero quotient is all ones regardless of dividend sign; the abs-value
  // datapath already yields remainder = dividend and handles 0x80000000 / -1.
  assign prod = negq_q ? -acc_q : acc_q;
  assign quo  = bzero_q ? 32'hFFFF_FFFF : (negq_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem  = negr_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    case (op_q)
      ALU_MUL:                         result_o = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = prod[63:32];
      ALU_DIV, ALU_DIVU:               result_o = quo;
      default:                         result_o = rem;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/execute.sv
// RISC-V EX stage: forwarding muxes, single-cycle ALU, branch compare, iterative M unit, EX/MEM register.
// Latency: 1 cycle for ALU ops; M ops occupy 34 cycles (33 with Stall high, result captured in DONE).
// Backpressure: Stall (combinational) holds upstream while an M op runs; EX/MEM loads bubbles meanwhile.
// Ports: clk, reset (async active-low); ID/EX controls + operands; ForwardA/B with mem/wb data;
//        flush kill; registered EX/MEM outputs; Stall.
module execute
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_ALUSrc,
  input  logic        Ctl_Branch_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [4:0]  ALUop_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] Immediate_in,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  output logic        Ctl_Branch_out,
  output logic        Ctl_MemRead_out,
  output logic        Ctl_MemWrite_out,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic        Zero_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] Write_Data_out,
  output logic [31:0] PCimm_out,
  output logic [31:0] PC_out,
  output logic        Stall
);

  logic [31:0] op_a, fwd_b, op_b, alu_res, md_res;
  logic        is_mop, md_busy, md_done, md_idle, md_start, bubble;
  exmem_t      exmem_q, exmem_d;

  always_comb begin
    case (ForwardA)
      FWD_WB:  op_a = wb_fwd_data;
      FWD_MEM: op_a = mem_fwd_data;
      default: op_a = ReadData1_in;
    endcase
    case (ForwardB)
      FWD_WB:  fwd_b = wb_fwd_data;
      FWD_MEM: fwd_b = mem_fwd_data;
      default: fwd_b = ReadData2_in;
    endcase
  end

  assign op_b = Ctl_ALUSrc ? Immediate_in : fwd_b;

  always_comb begin
    case (ALUop_in)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < op_b};
      default:  alu_res = 32'd0;
    endcase
  end

  assign is_mop   = ALUop_in[4];
  assign md_idle  = !md_busy && !md_done;
  assign md_start = md_idle && is_mop && !flush;

  // A flush kills the op, so it never stalls; DONE releases the pipeline while the op is still present.
  assign Stall  = reset && !flush && ((md_idle && is_mop) || md_busy);
  assign bubble = Stall || flush;

  muldiv_iter u_muldiv (
    .clk      (clk),
    .rst_n    (reset),
    .start_i  (md_start),
    .abort_i  (flush),
    .op_i     (ALUop_in),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_comb begin
    exmem_d            = '0;
    exmem_d.rd         = Rd_in;
    exmem_d.alu_result = md_done ? md_res : alu_res;
    exmem_d.write_data = fwd_b;
    exmem_d.pc_imm     = PC_in + Immediate_in;
    exmem_d.pc         = PC_in;
    if (!bubble) begin
      exmem_d.branch     = Ctl_Branch_in;
      exmem_d.mem_read   = Ctl_MemRead_in;
      exmem_d.mem_write  = Ctl_MemWrite_in;
      exmem_d.mem_to_reg = Ctl_MemtoReg_in;
      exmem_d.reg_write  = Ctl_RegWrite_in;
      exmem_d.jal        = jal_in;
      exmem_d.jalr       = jalr_in;
      exmem_d.zero       = br_taken(funct3_in, op_a, fwd_b);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign Ctl_Branch_out   = exmem_q.branch;
  assign Ctl_MemRead_out  = exmem_q.mem_read;
  assign Ctl_MemWrite_out = exmem_q.mem_write;
  assign Ctl_MemtoReg_out = exmem_q.mem_to_reg;
  assign Ctl_RegWrite_out = exmem_q.reg_write;
  assign jal_out          = exmem_q.jal;
  assign jalr_out         = exmem_q.jalr;
  assign Zero_out         = exmem_q.zero;
  assign Rd_out           = exmem_q.rd;
  assign ALUresult_out    = exmem_q.alu_result;
  assign Write_Data_out   = exmem_q.write_data;
  assign PCimm_out        = exmem_q.pc_imm;
  assign PC_out           = exmem_q.pc;

endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: reset, ALU/forwarding, branches, M ops, flush and reset aborts.
// Expected ALU results are queued when an op is driven and popped when the EX/MEM register shows it.
module tb_execute;
  import riscv_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Ctl_ALUSrc, Ctl_Branch_in, Ctl_MemRead_in, Ctl_MemWrite_in;
  logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, jal_in, jalr_in;
  logic [4:0]  ALUop_in;
  logic [2:0]  funct3_in;
  logic [4:0]  Rd_in;
  logic [31:0] PC_in, ReadData1_in, ReadData2_in, Immediate_in;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        flush;
  logic        Ctl_Branch_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_MemtoReg_out;
  logic        Ctl_RegWrite_out, jal_out, jalr_out, Zero_out;
  logic [4:0]  Rd_out;
  logic [31:0] ALUresult_out, Write_Data_out, PCimm_out, PC_out;
  logic        Stall;

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .reset(reset),
    .Ctl_ALUSrc(Ctl_ALUSrc), .Ctl_Branch_in(Ctl_Branch_in), .Ctl_MemRead_in(Ctl_MemRead_in),
    .Ctl_MemWrite_in(Ctl_MemWrite_in), .Ctl_MemtoReg_in(Ctl_MemtoReg_in),
    .Ctl_RegWrite_in(Ctl_RegWrite_in), .jal_in(jal_in), .jalr_in(jalr_in),
    .ALUop_in(ALUop_in), .funct3_in(funct3_in), .Rd_in(Rd_in), .PC_in(PC_in),
    .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .Immediate_in(Immediate_in),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .flush(flush),
    .Ctl_Branch_out(Ctl_Branch_out), .Ctl_MemRead_out(Ctl_MemRead_out),
    .Ctl_MemWrite_out(Ctl_MemWrite_out), .Ctl_MemtoReg_out(Ctl_MemtoReg_out),
    .Ctl_RegWrite_out(Ctl_RegWrite_out), .jal_out(jal_out), .jalr_out(jalr_out),
    .Zero_out(Zero_out), .Rd_out(Rd_out), .ALUresult_out(ALUresult_out),
    .Write_Data_out(Write_Data_out), .PCimm_out(PCimm_out), .PC_out(PC_out), .Stall(Stall)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_res();
    chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk(tag_q.pop_front(), ALUresult_out, exp_q.pop_front());
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUop_in        = op;
    ReadData1_in    = a;
    ReadData2_in    = b;
    ForwardA        = FWD_RF;
    ForwardB        = FWD_RF;
    Ctl_ALUSrc      = 1'b0;
    Ctl_RegWrite_in = 1'b1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  // Present an M op, count stalled cycles (each must load a bubble), then check the captured result.
  task automatic run_mop(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int   n = 0;
    logic bub_ok = 1'b1;
    drive(op, a, b);
    flush = 1'b0;
    expect_res(tag, exp);
    #1;
    while (Stall === 1'b1 && n < 100) begin
      tick();
      n++;
      if (Ctl_RegWrite_out !== 1'b0 || Zero_out !== 1'b0) bub_ok = 1'b0;
    end
    chk({tag, "_stall_cycles"}, n, 32'd33);
    chk({tag, "_bubbles"}, 32'(bub_ok), 32'd1);
    tick();
    check_res();
    chk({tag, "_regwrite"}, 32'(Ctl_RegWrite_out), 32'd1);
    drive(ALU_ADD, 32'd0, 32'd0);
    Ctl_RegWrite_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    Ctl_Branch_in = 1'b0; Ctl_MemRead_in = 1'b0; Ctl_MemWrite_in = 1'b0; Ctl_MemtoReg_in = 1'b0;
    jal_in = 1'b1; jalr_in = 1'b0; funct3_in = F3_BEQ; Rd_in = 5'd9;
    PC_in = 32'h100; Immediate_in = 32'h20; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
    drive(ALU_MUL, 32'd3, 32'd3);

    // Reset: outputs cleared and Stall low even with an M op on the inputs.
    repeat (3) tick();
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_regwrite", 32'(Ctl_RegWrite_out), 32'd0);
    chk("rst_jal", 32'(jal_out), 32'd0);
    chk("rst_pc", PC_out, 32'd0);
    chk("rst_alu", ALUresult_out, 32'd0);

    // ADD with MEM forwarding on A.
    reset = 1'b1; jal_in = 1'b0; Rd_in = 5'd3;
    drive(ALU_ADD, 32'd99, 32'd7);
    ForwardA = FWD_MEM; mem_fwd_data = 32'd5;
    expect_res("add_fwd_mem", 32'd12);
    #1 chk("add_stall", 32'(Stall), 32'd0);
    tick();
    check_res();
    chk("add_pcimm", PCimm_out, 32'h120);
    chk("add_rd", 32'(Rd_out), 32'd3);
    chk("add_wdata", Write_Data_out, 32'd7);
    chk("add_regwrite", 32'(Ctl_RegWrite_out), 32'd1);

    // SUB with immediate B, WB forward on A, MEM forward feeding store data.
    drive(ALU_SUB, 32'd1, 32'd2);
    ForwardA = FWD_WB; wb_fwd_data = 32'd100; Ctl_ALUSrc = 1'b1; Immediate_in = 32'd30;
    ForwardB = FWD_MEM; mem_fwd_data = 32'd77; PC_in = 32'hFFFF_FFF0;
    expect_res("sub_imm", 32'd70);
    tick();
    check_res();
    chk("sub_wdata_fwdb", Write_Data_out, 32'd77);
    chk("pcimm_wrap", PCimm_out, 32'h0000_000E);

    // Branch compares use forwarded B.
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    Ctl_Branch_in = 1'b1; funct3_in = F3_BLT;
    tick();
    chk("blt_zero", 32'(Zero_out), 32'd1);
    chk("branch_pass", 32'(Ctl_Branch_out), 32'd1);
    funct3_in = F3_BLTU;
    tick();
    chk("bltu_zero", 32'(Zero_out), 32'd0);
    Ctl_Branch_in = 1'b0; funct3_in = F3_BEQ;

    // Directed shift/compare corners.
    drive(ALU_SRA, 32'h8000_0000, 32'd36); expect_res("sra_amt_low5", 32'hF800_0000); tick(); check_res();
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);  expect_res("slt_neg", 32'd1);             tick(); check_res();
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1); expect_res("sltu_big", 32'd0);            tick(); check_res();

    for (int i = 0; i < 8; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = 5'($urandom_range(0, 9));
      a  = $urandom;
      b  = $urandom;
      drive(op, a, b);
      expect_res($sformatf("rand_alu%0d", i), ref_alu(op, a, b));
      tick();
      check_res();
    end

    // M ops.
    run_mop("mul",     ALU_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_mop("mulhu",   ALU_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    run_mop("mulh",    ALU_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    run_mop("mulhsu",  ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mop("div_neg", ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_mop("rem_neg", ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_mop("divu_z",  ALU_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF);
    run_mop("remu_z",  ALU_REMU,   32'd9,         32'd0,         32'd9);
    run_mop("div_ovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("rem_ovf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_mop("div_z_s", ALU_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);

    // Flush at BUSY counter 10.
    drive(ALU_DIVU, 32'd50, 32'd3);
    #1 chk("flush_pre_stall", 32'(Stall), 32'd1);
    repeat (11) tick();
    flush = 1'b1;
    #1 chk("flush_busy_stall", 32'(Stall), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_busy_bubble", 32'(Ctl_RegWrite_out), 32'd0);
    drive(ALU_ADD, 32'd1, 32'd1);
    expect_res("add_after_flush", 32'd2);
    #1 chk("flush_idle_after", 32'(Stall), 32'd0);
    tick();
    check_res();

    // Flush in IDLE with an M op present must not start the unit.
    drive(ALU_MUL, 32'd3, 32'd4);
    flush = 1'b1;
    #1 chk("flush_idle_stall", 32'(Stall), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_idle_bubble", 32'(Ctl_RegWrite_out), 32'd0);
    drive(ALU_ADD, 32'd2, 32'd3);
    #1 chk("flush_idle_nostart", 32'(Stall), 32'd0);
    tick();

    // Flush in DONE wins over result capture.
    begin
      int n = 0;
      drive(ALU_MUL, 32'd6, 32'd7);
      #1;
      while (Stall === 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("done_flush_reach", n, 32'd33);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("done_flush_bubble", 32'(Ctl_RegWrite_out), 32'd0);
      drive(ALU_ADD, 32'd2, 32'd3);
      expect_res("add_after_done_flush", 32'd5);
      #1 chk("done_flush_idle", 32'(Stall), 32'd0);
      tick();
      check_res();
    end

    // Reset mid-BUSY: asynchronous clear, then a clean divide.
    drive(ALU_MUL, 32'd5, 32'd5);
    PC_in = 32'h40; Immediate_in = 32'h10;
    repeat (5) tick();
    chk("pre_reset_stall", 32'(Stall), 32'd1);
    chk("pre_reset_pcimm", PCimm_out, 32'h50);
    reset = 1'b0;
    #1;
    chk("async_rst_pcimm", PCimm_out, 32'd0);
    chk("async_rst_pc", PC_out, 32'd0);
    chk("async_rst_rd", 32'(Rd_out), 32'd0);
    chk("async_rst_stall", 32'(Stall), 32'd0);
    tick();
    chk("rst_no_result", ALUresult_out, 32'd0);
    reset = 1'b1;
    run_mop("divu_after_rst", ALU_DIVU, 32'd100, 32'd7, 32'd14);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have ports clk (in, 1, single clock, rising edge) and reset (in, 1, asynchronous active-low reset).
REQ-002 SHALL have inputs Ctl_ALUSrc, Ctl_Branch_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, jal_in, jalr_in (1 each), the ID/EX control bits.
REQ-003 SHALL have inputs ALUop_in (5, operation code from the shared package) and funct3_in (3, branch condition select).
REQ-004 SHALL have inputs Rd_in (5), PC_in, ReadData1_in, ReadData2_in, Immediate_in (32 each).
REQ-005 SHALL have inputs ForwardA, ForwardB (2 each; 00 = register file, 01 = WB data, 10 = MEM data), mem_fwd_data and wb_fwd_data (32 each).
REQ-006 SHALL have input flush (1), the branch-taken kill from the downstream stage.
REQ-007 SHALL have outputs Ctl_Branch_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, jal_out, jalr_out, Zero_out (1 each), Rd_out (5), and ALUresult_out, Write_Data_out, PCimm_out, PC_out (32 each), all registered EX/MEM.
REQ-008 SHALL have output Stall (1, combinational), which holds all upstream stages.

Function
REQ-009 Operand A SHALL be the ForwardA-selected value; forwarded B SHALL be the ForwardB-selected value; operand B SHALL be Immediate_in when Ctl_ALUSrc=1, else forwarded B.
REQ-010 Single-cycle ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount B[4:0]), SLT, and SLTU, with the result captured at the next edge.
REQ-011 Zero_out SHALL be the branch condition selected by funct3_in: BEQ, BNE, BLT, BGE, BLTU, or BGEU on A vs forwarded B.
REQ-012 PCimm_out SHALL be PC_in + Immediate_in modulo 2^32; Write_Data_out SHALL be forwarded B; PC_out, Rd_out, and control bits SHALL pass through unchanged.
REQ-013 M ops SHALL be MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, and REMU, executed iteratively at one bit per cycle.
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 In IDLE with an M op present, Stall SHALL be 1 in the same cycle, operands SHALL be latched, the counter SHALL be cleared to 0, and the next state SHALL be BUSY.
REQ-016 In BUSY, Stall SHALL be 1, the counter SHALL increment each cycle, and after 32 iterations (counter 31) the next state SHALL be DONE.
REQ-017 In DONE, Stall SHALL be 0, the M result SHALL be captured into EX/MEM at that edge, and the next state SHALL be IDLE; the still-present op SHALL NOT restart the unit.
REQ-018 An M op SHALL occupy 34 cycles from first presentation to result capture.
REQ-019 While Stall=1, EX/MEM SHALL load a bubble: all Ctl_*, jal_out, jalr_out, and Zero_out at 0.
REQ-020 Division by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-021 Signed 0x80000000 / -1 SHALL give quotient 0x80000000 and remainder 0.
REQ-022 Signed divide SHALL follow RISC-V truncation: the remainder sign SHALL equal the dividend sign.
REQ-023 flush=1 SHALL load a bubble into EX/MEM at the next edge; in BUSY or DONE it SHALL also abort the FSM to IDLE, with Stall=0 in that cycle.
REQ-024 flush SHALL take priority over DONE capture.
REQ-025 flush in IDLE with an M op present SHALL NOT start the unit.

Reset
REQ-026 reset=0 SHALL immediately force all EX/MEM outputs to 0, FSM to IDLE, counter to 0, and the operand/accumulator registers to 0.
REQ-027 Stall SHALL be 0 while reset is asserted.
REQ-028 Reset during BUSY SHALL abandon the operation with no result written.
REQ-029 After reset deassertion, the first edge SHALL behave as in IDLE.

Structure
REQ-030 ALUop encodings, Forward select codes, funct3 branch codes, and FSM state encodings SHALL live in shared package riscv_defs.
REQ-031 The iterative unit SHALL be sub-module muldiv_iter, with a start/busy/done handshake, op, a, b, and a 32-bit result; the ALU, forwarding, and EX/MEM register stay in execute.

Verification
REQ-032 ADD with ForwardA=10, mem_fwd_data=5, ReadData2=7, ALUSrc=0 -> ALUresult_out=12 one edge later, and Stall stays 0.
REQ-033 BLT with A=0xFFFFFFFF, B=1 -> Zero_out=1; BLTU with the same operands -> Zero_out=0.
REQ-034 MUL 0x00010000 x 0x00010000 -> Stall high exactly 33 cycles, EX/MEM bubbles during stall, then ALUresult_out=0; MULHU with the same operands -> 0x00000001.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 9 / 0 -> 0xFFFFFFFF; REMU 9 % 0 -> 9; DIV 0x80000000 / -1 -> 0x80000000.
REQ-036 flush at BUSY counter 10 -> next cycle Stall=0, FSM IDLE, EX/MEM bubble; a following ADD 1+1 -> 2 with no residual stall.
REQ-037 reset=0 mid-BUSY -> all outputs 0 asynchronously, Stall=0; after release, a DIVU 100 / 7 completes in 34 cycles with result 14.
